bcd_operand_entry: RTL

Parametrised keypad operand-entry unit for the calculator datapath.
- Collects BCD digits from the keypad into an N-digit buffer, with backspace, clear and sign toggle.
- Drives a live display value.
- Hands a completed operand to the operand register over a valid/ready handshake.
- Generalises the fixed 4-digit number-entry FSM with configurable depth, editing keys, overflow reporting and a proper commit handshake.

---
 rtl/bcd_operand_entry.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/bcd_operand_entry.sv
// bcd_operand_entry: keypad BCD operand entry buffer with editing keys and a valid/ready commit handshake
module bcd_operand_entry #(
    parameter int NUM_DIGITS = 4,
    parameter bit SIGNED_EN  = 1'b1
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               entry_en,
    input  logic                               key_valid,
    input  logic [3:0]                         key_code,
    input  logic                               op_ready,
    output logic                               op_valid,
    output logic [4*NUM_DIGITS-1:0]            op_value,
    output logic                               op_neg,
    output logic [4*NUM_DIGITS-1:0]            disp_value,
    output logic                               disp_neg,
    output logic [$clog2(NUM_DIGITS+1)-1:0]    digit_count,
    output logic                               disp_update,
    output logic                               overflow,
    output logic                               busy
);
    localparam int W  = 4 * NUM_DIGITS;
    localparam int CW = $clog2(NUM_DIGITS + 1);

    typedef enum logic [1:0] {IDLE, ENTRY, COMMIT} state_t;

    state_t          state_q, state_d;
    logic            key_prev_q;
    logic [W-1:0]    buf_q, buf_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            neg_q, neg_d;
    logic            ovf_q, ovf_d;
    logic            upd_q, upd_d;
    logic            vld_q, vld_d;
    logic [W-1:0]    val_q, val_d;
    logic            oneg_q, oneg_d;
    logic            ev;
    logic            full;

    assign ev   = key_valid & ~key_prev_q;
    assign full = cnt_q == CW'(NUM_DIGITS);

    // Next-state: mode transitions and key editing, acted on only while in ENTRY
    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        cnt_d   = cnt_q;
        neg_d   = neg_q;
        ovf_d   = ovf_q;
        upd_d   = 1'b0;
        vld_d   = vld_q;
        val_d   = val_q;
        oneg_d  = oneg_q;
        case (state_q)
            IDLE: begin
                if (entry_en) begin
                    state_d = ENTRY;
                    buf_d   = '0;
                    cnt_d   = '0;
                    neg_d   = 1'b0;
                    ovf_d   = 1'b0;
                end
            end
            ENTRY: begin
                if (!entry_en) begin
                    state_d = IDLE;
                    buf_d   = '0;
                    cnt_d   = '0;
                    neg_d   = 1'b0;
                end else if (ev) begin
                    if (key_code <= 4'd9) begin
                        if (full) begin
                            ovf_d = 1'b1;
                        end else if (cnt_q != '0 || key_code != 4'd0) begin
                            buf_d = (buf_q << 4) | W'(key_code);
                            cnt_d = cnt_q + CW'(1);
                            upd_d = 1'b1;
                        end
                    end else if (key_code == 4'hA) begin
                        if (cnt_q != '0) begin
                            buf_d = buf_q >> 4;
                            cnt_d = cnt_q - CW'(1);
                            neg_d = (cnt_q == CW'(1)) ? 1'b0 : neg_q;
                            upd_d = 1'b1;
                        end
                    end else if (key_code == 4'hB) begin
                        buf_d = '0;
                        cnt_d = '0;
                        neg_d = 1'b0;
                        ovf_d = 1'b0;
                        upd_d = 1'b1;
                    end else if (key_code == 4'hC) begin
                        if (SIGNED_EN && cnt_q != '0) begin
                            neg_d = ~neg_q;
                            upd_d = 1'b1;
                        end
                    end else if (key_code == 4'hE) begin
                        state_d = COMMIT;
                        val_d   = buf_q;
                        oneg_d  = neg_q & (cnt_q != '0);
                        vld_d   = 1'b1;
                        ovf_d   = 1'b0;
                    end
                end
            end
            COMMIT: begin
                if (vld_q && op_ready) begin
                    state_d = IDLE;
                    vld_d   = 1'b0;
                    buf_d   = '0;
                    cnt_d   = '0;
                    neg_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset drops any pending offer immediately
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            key_prev_q <= 1'b0;
            buf_q      <= '0;
            cnt_q      <= '0;
            neg_q      <= 1'b0;
            ovf_q      <= 1'b0;
            upd_q      <= 1'b0;
            vld_q      <= 1'b0;
            val_q      <= '0;
            oneg_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            key_prev_q <= key_valid;
            buf_q      <= buf_d;
            cnt_q      <= cnt_d;
            neg_q      <= neg_d;
            ovf_q      <= ovf_d;
            upd_q      <= upd_d;
            vld_q      <= vld_d;
            val_q      <= val_d;
            oneg_q     <= oneg_d;
        end
    end

    assign op_valid    = vld_q;
    assign op_value    = val_q;
    assign op_neg      = oneg_q;
    assign disp_value  = buf_q;
    assign disp_neg    = neg_q;
    assign digit_count = cnt_q;
    assign disp_update = upd_q;
    assign overflow    = ovf_q;
    assign busy        = state_q != IDLE;
endmodule
